// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for pipe_stage_skid: derived-state encoding and per-stage payload reset values.
package pipe_stage_skid_pkg;

    // State is {skid_v, main_v}; 2'b10 can never occur.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b11;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_FULL  = ST_FULL,
        S_SKID  = ST_SKID
    } stage_state_e;

    localparam int DEF_DATA_W = 107;

    // MEM/WB stage: the PC field sits in the low 32 bits of the payload.
    localparam int          MEMWB_PC_LSB = 0;
    localparam logic [31:0] MEMWB_PC_RST = 32'h0040_0000;
    localparam logic [DEF_DATA_W-1:0] MEMWB_RST_PAYLOAD =
        DEF_DATA_W'(MEMWB_PC_RST) << MEMWB_PC_LSB;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module pipe_sat_counter
    import pipe_stage_skid_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer, flush and configurable reset payload.
// Optional saturating stall counter on stall_cnt when PIPE_STAGE_STALL_CNT_EN is defined.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RST_PAYLOAD = {DATA_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;

    logic              main_v_n;
    logic              skid_v_n;
    logic [DATA_W-1:0] main_d_n;
    logic [DATA_W-1:0] skid_d_n;

    stage_state_e      state;

    assign state     = stage_state_e'({skid_v, main_v});
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;

    // Next-state: in SKID in_ready is low, so in_valid is deliberately ignored there.
    always_comb begin
        main_v_n = main_v;
        skid_v_n = skid_v;
        main_d_n = main_d;
        skid_d_n = skid_d;
        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
            main_d_n = RST_PAYLOAD;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_valid) begin
                        main_v_n = 1'b1;
                        main_d_n = in_data;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            main_d_n = in_data;
                        end else begin
                            main_v_n = 1'b0;
                        end
                    end else if (in_valid) begin
                        skid_v_n = 1'b1;
                        skid_d_n = in_data;
                    end
                end
                S_SKID: begin
                    if (out_ready) begin
                        main_d_n = skid_d;
                        skid_v_n = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= RST_PAYLOAD;
            skid_d <= '0;
        end else begin
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            main_d <= main_d_n;
            skid_d <= skid_d_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (state == S_EMPTY || state == S_FULL || state == S_SKID);
        end
    end

    // A zero-width counter is a configuration error; trap it in simulation.
    if (CNT_W < 1) begin : g_bad_cnt_w
        always_ff @(posedge clk) begin
            assert (1'b0);
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (main_v & !out_ready),
        .count (stall_cnt)
    );
`endif

endmodule
